demux_2_output: RTL and testbench
=================================

// Module: demux_2_output
// PURPOSE
//   Registered 1-to-2 stream demultiplexer: the inverse of the 2-input mux. Accepts one
//   valid/ready input stream and routes each word, by a per-word select bit, into one of
//   two buffered output streams. Used in the RISC-V core wherever one producer feeds two
//   consumers, e.g. splitting writeback results between register file and CSR path.
//   Each output has its own FIFO, so a stalled consumer never corrupts the other path.
// PARAMETERS
//   size   32  data width of input and both outputs
//   DEPTH  2   entries per output FIFO; power of two, >= 2
// PORTS
//   clk          in   1                  clock, rising edge
//   rst_n        in   1                  asynchronous reset, active-low
//   flush        in   1                  synchronous clear of both output FIFOs
//   in_valid     in   1                  input word present
//   in_ready     out  1                  input word accepted this cycle when in_valid=1
//   in_sel       in   1                  destination: 0 -> output 0, 1 -> output 1
//   in_data      in   size               input word
//   out0_valid   out  1                  output 0 word present
//   out0_ready   in   1                  output 0 consumer takes the word
//   out0_data    out  size               output 0 head word
//   out1_valid   out  1                  output 1 word present
//   out1_ready   in   1                  output 1 consumer takes the word
//   out1_data    out  size               output 1 head word
//   out0_count   out  $clog2(DEPTH+1)    occupancy of output 0 FIFO
//   out1_count   out  $clog2(DEPTH+1)    occupancy of output 1 FIFO
// BEHAVIOUR
//   - Reset (rst_n=0, async): all FIFOs empty; outN_valid=0, outN_count=0,
//     outN_data=0; in_ready=1 once rst_n deasserts. Reset mid-transfer discards all data.
//   - Push: in_valid & in_ready; word written to FIFO in_sel at the clock edge.
//   - in_ready = !full(FIFO[in_sel]) & !flush. No dependence on outN_ready (no comb path
//     from consumer ready to producer ready). Full FIFO blocks input even if popping.
//   - Producer rule: in_data/in_sel held stable while in_valid & !in_ready.
//   - Pop: outN_valid & outN_ready; head advances at clock edge.
//   - Latency: word accepted at edge k is visible on outN at cycle k+1 (one register).
//   - outN_valid = (countN != 0); outN_data = FIFO head, registered storage, no bypass.
//   - Simultaneous push and pop on same non-full FIFO: count unchanged, both happen.
//   - Push to one FIFO while popping the other: independent, both take effect.
//   - Pointers: log2(DEPTH) bits, wrap naturally mod DEPTH; count separate register.
//   - Ordering: per-output FIFO order preserved; no ordering relation across outputs.
//   - flush=1: next edge sets both counts and pointers to 0; pushes and pops that cycle
//     are ignored; outN_valid=0 the cycle after. flush has priority over push/pop.
//   - Overflow/underflow impossible by construction; assertions check push&full=0,
//     pop&empty=0.
// STRUCTURE
//   - Package demux_pkg: typedef logic port_sel_t; localparam PORT_0=1'b0, PORT_1=1'b1.
//   - Sub-module demux_fifo (size, DEPTH): single-clock FIFO with push, pop, flush,
//     full, empty, count, head data; instantiated twice, once per output.
//   - Top: select decode, in_ready generation, two demux_fifo instances.
// TESTING
//   1 Reset: rst_n=0 then 1 -> out0_valid=out1_valid=0, counts=0, in_ready=1.
//   2 Route: push 32'hDEADBEEF sel=0 -> next cycle out0_valid=1, out0_data=DEADBEEF,
//     out1_valid=0; out0_ready=1 -> out0_valid=0 following cycle.
//   3 Backpressure: out1_ready=0, push A,B,C sel=1 (DEPTH=2) -> A,B accepted,
//     out1_count=2, in_ready=0 for C; out1_ready=1 -> A,B,C drain in order.
//   4 Isolation + wrap: out1 stalled full, 10 words sel=0 with out0_ready=1 -> all 10
//     accepted, out0 order preserved through pointer wrap, out1_count stays 2.
//   5 Flush: both FIFOs holding 2 words, flush=1 with in_valid=1 -> in_ready=0, counts=0
//     after edge, no output valid next cycle, pushed word lost.
//   6 Async reset mid-stream: rst_n low between edges -> outN_valid=0 immediately,
//     counts=0 without waiting for clk.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux_pkg;

  typedef logic port_sel_t;

  localparam port_sel_t PORT_0 = 1'b0;
  localparam port_sel_t PORT_1 = 1'b1;

  function automatic logic is_port1(input port_sel_t sel);
    return (sel == PORT_1);
  endfunction

endpackage

// File: rtl/demux_2_output_if.sv
// Stream bundle for demux_2_output: one input stream, two buffered output streams.
interface demux_2_output_if #(
  parameter int unsigned size  = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [size-1:0]  in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [size-1:0]  out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [size-1:0]  out1_data;
  logic [CNT_W-1:0] out0_count;
  logic [CNT_W-1:0] out1_count;

  // master: producer/consumers around the demux; slave: the demux itself
  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
           out0_count, out1_count
  );

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data,
           out0_count, out1_count
  );

endinterface

// File: rtl/demux_fifo.sv
// Single-clock FIFO with registered head, synchronous flush and explicit occupancy count.
module demux_fifo #(
  parameter int unsigned size  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [size-1:0]              wdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [size-1:0]              head
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [size-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/demux_2_output.sv
// Registered 1-to-2 stream demultiplexer: routes each input word by in_sel into one of
// two independent output FIFOs so a stalled consumer never blocks the other path.
module demux_2_output
  import demux_pkg::*;
#(
  parameter int unsigned size  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  demux_2_output_if.slave     bus
);

  port_sel_t sel;
  logic      full0, full1;
  logic      empty0, empty1;
  logic      push0, push1;
  logic      pop0, pop1;

  assign sel = bus.in_sel;

  // in_ready looks only at the selected FIFO's full flag, never at the consumer readies
  always_comb begin
    bus.in_ready = 1'b0;
    push0        = 1'b0;
    push1        = 1'b0;
    bus.in_ready = !(is_port1(sel) ? full1 : full0) && !flush;
    push0        = bus.in_valid && bus.in_ready && (sel == PORT_0);
    push1        = bus.in_valid && bus.in_ready && (sel == PORT_1);
  end

  assign bus.out0_valid = !empty0;
  assign bus.out1_valid = !empty1;
  assign pop0 = bus.out0_valid && bus.out0_ready;
  assign pop1 = bus.out1_valid && bus.out1_ready;

  demux_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push0),
    .pop   (pop0),
    .wdata (bus.in_data),
    .full  (full0),
    .empty (empty0),
    .count (bus.out0_count),
    .head  (bus.out0_data)
  );

  demux_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push1),
    .pop   (pop1),
    .wdata (bus.in_data),
    .full  (full1),
    .empty (empty1),
    .count (bus.out1_count),
    .head  (bus.out1_data)
  );

endmodule

// File: tb/tb_demux_2_output.sv
// Directed, table-driven bench for demux_2_output (size=32, DEPTH=2).
module tb_demux_2_output;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int errors = 0;
  int checks = 0;

  demux_2_output_if #(.size(32), .DEPTH(2)) bus ();

  demux_2_output #(.size(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        valid;
    logic        sel;
    logic [31:0] data;
    logic        r0;
    logic        r1;
    logic        exp_ir;
    logic [31:0] exp_d0;
    logic [1:0]  exp_c0;
    logic [31:0] exp_d1;
    logic [1:0]  exp_c1;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic fl, valid, sel, input logic [31:0] data,
                              input logic r0, r1, exp_ir,
                              input logic [31:0] exp_d0, input logic [1:0] exp_c0,
                              input logic [31:0] exp_d1, input logic [1:0] exp_c1);
    vec_t v;
    v.fl = fl; v.valid = valid; v.sel = sel; v.data = data; v.r0 = r0; v.r1 = r1;
    v.exp_ir = exp_ir; v.exp_d0 = exp_d0; v.exp_c0 = exp_c0;
    v.exp_d1 = exp_d1; v.exp_c1 = exp_c1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at negedge, check in_ready before the edge, check registered state after it.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    flush          = v.fl;
    bus.in_valid   = v.valid;
    bus.in_sel     = v.sel;
    bus.in_data    = v.data;
    bus.out0_ready = v.r0;
    bus.out1_ready = v.r1;
    #1;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(v.exp_ir));
    @(posedge clk);
    #1;
    chk({tag, " out0_count"}, 32'(bus.out0_count), 32'(v.exp_c0));
    chk({tag, " out1_count"}, 32'(bus.out1_count), 32'(v.exp_c1));
    chk({tag, " out0_valid"}, 32'(bus.out0_valid), 32'(v.exp_c0 != 2'd0));
    chk({tag, " out1_valid"}, 32'(bus.out1_valid), 32'(v.exp_c1 != 2'd0));
    if (v.exp_c0 != 2'd0) chk({tag, " out0_data"}, bus.out0_data, v.exp_d0);
    if (v.exp_c1 != 2'd0) chk({tag, " out1_data"}, bus.out1_data, v.exp_d1);
  endtask

  localparam logic [31:0] A = 32'hA0A0_0001;
  localparam logic [31:0] B = 32'hB0B0_0002;
  localparam logic [31:0] C = 32'hC0C0_0003;
  localparam logic [31:0] X = 32'h1111_0001;
  localparam logic [31:0] Y = 32'h2222_0002;
  localparam logic [31:0] P = 32'h5050_0005;
  localparam logic [31:0] Q = 32'h6060_0006;
  localparam logic [31:0] R = 32'h7070_0007;
  localparam logic [31:0] S = 32'h8080_0008;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //             fl valid sel data          r0 r1 ir d0            c0 d1 c1
    tbl[0]  = mk(0, 1, 0, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,            1, 0, 1, 0,            0, 0, 0);
    tbl[2]  = mk(0, 1, 1, A,            0, 0, 1, 0,            0, A, 1);
    tbl[3]  = mk(0, 1, 1, B,            0, 0, 1, 0,            0, A, 2);
    tbl[4]  = mk(0, 1, 1, C,            0, 0, 0, 0,            0, A, 2);
    tbl[5]  = mk(0, 1, 1, C,            0, 1, 0, 0,            0, B, 1);
    tbl[6]  = mk(0, 1, 1, C,            0, 1, 1, 0,            0, C, 1);
    tbl[7]  = mk(0, 0, 1, C,            0, 1, 1, 0,            0, 0, 0);
    tbl[8]  = mk(0, 1, 0, P,            0, 0, 1, P,            1, X, 2);
    tbl[9]  = mk(0, 1, 0, Q,            0, 0, 1, P,            2, X, 2);
    tbl[10] = mk(1, 1, 0, S,            1, 1, 0, 0,            0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0,            0, 0, 1, 0,            0, 0, 0);
    tbl[12] = mk(0, 1, 1, R,            0, 0, 1, 0,            0, R, 1);
    tbl[13] = mk(1, 1, 0, S,            0, 0, 0, 0,            0, 0, 0);

    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_data = '0;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("reset out0_valid", 32'(bus.out0_valid), 32'd0);
    chk("reset out1_valid", 32'(bus.out1_valid), 32'd0);
    chk("reset out0_count", 32'(bus.out0_count), 32'd0);
    chk("reset out1_count", 32'(bus.out1_count), 32'd0);
    chk("reset out0_data",  bus.out0_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);

    // Routing and backpressure
    for (int i = 0; i <= 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Out1 stalled full while ten words stream through out0 across pointer wrap
    run_vec(mk(0, 1, 1, X, 0, 0, 1, 0, 0, X, 1), "iso_fill_x");
    run_vec(mk(0, 1, 1, Y, 0, 0, 1, 0, 0, X, 2), "iso_fill_y");
    for (int i = 0; i < 10; i++) begin
      logic [31:0] w;
      w = 32'h4000_0000 + 32'(i);
      run_vec(mk(0, 1, 0, w, 1, 0, 1, w, 1, X, 2), $sformatf("iso_w%0d", i));
    end
    run_vec(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, X, 2), "iso_drain");

    // Flush with both FIFOs full, then flush against an empty target
    for (int i = 8; i <= 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Async reset between edges
    run_vec(mk(0, 1, 0, P, 0, 0, 1, P, 1, 0, 0), "ar_push0");
    run_vec(mk(0, 1, 1, Q, 0, 0, 1, P, 1, Q, 1), "ar_push1");
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out0_valid", 32'(bus.out0_valid), 32'd0);
    chk("async out1_valid", 32'(bus.out1_valid), 32'd0);
    chk("async out0_count", 32'(bus.out0_count), 32'd0);
    chk("async out1_count", 32'(bus.out1_count), 32'd0);
    chk("async out1_data",  bus.out1_data, 32'd0);
    chk("async in_ready",   32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    v = mk(0, 1, 1, S, 0, 0, 1, 0, 0, S, 1);
    run_vec(v, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
